// File: rtl/traffic_generator.sv
// Traffic generator for a mesh router local port: forms packets with a
// fixed or LFSR-random destination and requests the router with gaps.
module traffic_generator #(
    parameter logic [5:0] routerID    = 6'b000_000,
    parameter logic [5:0] ModuleID    = 6'b000_000,
    parameter int         dataWidth   = 32,
    parameter int         dim         = 4,
    parameter int         GAP         = 4,
    parameter int         NUM_PACKETS = 0,
    parameter int         DEST_MODE   = 1,
    parameter logic [5:0] DEST_ID     = 6'b011_011,
    parameter logic [7:0] SEED        = 8'hA5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 Enable,
    input  logic                 DnStrFull,
    input  logic                 GntDnStr,
    output logic                 ReqDnStr,
    output logic [dataWidth-1:0] PacketOut,
    output logic [15:0]          SentCount,
    output logic                 Done
);

    localparam int CW = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [CW-1:0] gapInit = CW'(GAP);
    localparam logic [7:0] seedVal = (SEED == 8'h00) ? 8'h01 : SEED;
    localparam logic [2:0] maxCoord = 3'(dim - 1);
    localparam logic [15:0] numTarget = 16'(NUM_PACKETS);

    typedef enum logic {
        sGap = 1'b0,
        sReq = 1'b1
    } state_t;

    state_t        state;
    logic [CW-1:0] gapCnt;
    logic [7:0]    lfsr;
    logic [9:0]    packetID;
    logic [2:0]    rawX;
    logic [2:0]    rawY;
    logic [2:0]    coordX;
    logic [2:0]    coordY;
    logic [5:0]    dest;
    logic [31:0]   packet;
    logic [7:0]    lfsrNext;
    logic          lastPacket;

    // Fibonacci step for x^8+x^6+x^5+x^4+1, shifting left.
    assign lfsrNext = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

    // Random coordinates come from the low LFSR nibble; small meshes clamp.
    always_comb begin
        rawX   = {1'b0, lfsr[1:0]};
        rawY   = {1'b0, lfsr[3:2]};
        coordX = (rawX > maxCoord) ? maxCoord : rawX;
        coordY = (rawY > maxCoord) ? maxCoord : rawY;
        if (DEST_MODE == 0) begin
            dest = DEST_ID;
        end else begin
            dest = {coordX, coordY};
        end
        packet = {10'b0, dest, packetID, ModuleID};
    end

    assign lastPacket = (NUM_PACKETS != 0)
                     && (SentCount + 16'd1 == numTarget);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= sGap;
            gapCnt    <= gapInit;
            lfsr      <= seedVal;
            packetID  <= '0;
            ReqDnStr  <= 1'b0;
            PacketOut <= '0;
            SentCount <= '0;
            Done      <= 1'b0;
        end else begin
            unique case (state)
                sGap: begin
                    if (gapCnt != '0) begin
                        if (Enable) begin
                            gapCnt <= gapCnt - 1'b1;
                        end
                    end else if (Enable && !DnStrFull && !Done) begin
                        if (dest != routerID) begin
                            ReqDnStr  <= 1'b1;
                            PacketOut <= dataWidth'(packet);
                            state     <= sReq;
                        end else begin
                            // Self-addressed draw: reroll next cycle.
                            lfsr <= lfsrNext;
                        end
                    end
                end
                sReq: begin
                    if (GntDnStr) begin
                        ReqDnStr  <= 1'b0;
                        packetID  <= packetID + 10'd1;
                        SentCount <= SentCount + 16'd1;
                        gapCnt    <= gapInit;
                        state     <= sGap;
                        if (DEST_MODE != 0) begin
                            lfsr <= lfsrNext;
                        end
                        if (lastPacket) begin
                            Done <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_traffic_generator.sv
// Scoreboard bench for traffic_generator: fixed-destination timing,
// random-destination sequence and packet-limit instances.
module tb_traffic_generator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int nChecks = 0;
    int nFail   = 0;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Instance A: fixed destination, no gap, unlimited packets.
    logic        aRst, aEn, aFull, aAuto, manGnt, aGnt, aReq, aDone;
    logic [31:0] aPkt;
    logic [15:0] aCnt;
    logic        colA = 1'b0;

    assign aGnt = aAuto ? colA : manGnt;

    traffic_generator #(
        .GAP(0), .DEST_MODE(0), .NUM_PACKETS(0)
    ) uA (
        .clk(clk), .reset(aRst), .Enable(aEn), .DnStrFull(aFull),
        .GntDnStr(aGnt), .ReqDnStr(aReq), .PacketOut(aPkt),
        .SentCount(aCnt), .Done(aDone)
    );

    // Instance B: random destinations, router at origin.
    logic        bRst, bEn, bReq, bDone;
    logic        bGnt = 1'b0;
    logic [31:0] bPkt;
    logic [15:0] bCnt;

    traffic_generator #(
        .routerID(6'b000_000), .ModuleID(6'h2A),
        .GAP(1), .DEST_MODE(1), .NUM_PACKETS(0), .SEED(8'hA5)
    ) uB (
        .clk(clk), .reset(bRst), .Enable(bEn), .DnStrFull(1'b0),
        .GntDnStr(bGnt), .ReqDnStr(bReq), .PacketOut(bPkt),
        .SentCount(bCnt), .Done(bDone)
    );

    // Instance C: three packets then stop.
    logic        cRst, cEn, cReq, cDone;
    logic        cGnt = 1'b0;
    logic [31:0] cPkt;
    logic [15:0] cCnt;

    traffic_generator #(
        .ModuleID(6'h11), .GAP(2), .DEST_MODE(0),
        .DEST_ID(6'b010_001), .NUM_PACKETS(3)
    ) uC (
        .clk(clk), .reset(cRst), .Enable(cEn), .DnStrFull(1'b0),
        .GntDnStr(cGnt), .ReqDnStr(cReq), .PacketOut(cPkt),
        .SentCount(cCnt), .Done(cDone)
    );

    // Collector-style grants: one cycle after the request is seen.
    always @(posedge clk) begin
        colA <= aAuto && aReq && !colA;
        bGnt <= bReq && !bGnt;
        cGnt <= cReq && !cGnt;
    end

    logic [31:0] qA[$];
    logic [31:0] qB[$];
    logic [31:0] qC[$];
    int          bBad = 0;

    always @(negedge clk) begin : monA
        logic [31:0] e;
        if (!aRst && aReq && aGnt) begin
            if (qA.size() == 0) begin
                check("A unexpected packet", aPkt, 32'hxxxxxxxx);
            end else begin
                e = qA.pop_front();
                check("A packet", aPkt, e);
            end
        end
    end

    always @(negedge clk) begin : monB
        logic [31:0] e;
        if (!bRst && bReq && bGnt) begin
            if (bPkt[21:16] == 6'b0 || bPkt[21] || bPkt[18]
                || bPkt[31:22] != 10'b0) begin
                bBad++;
            end
            if (qB.size() == 0) begin
                check("B unexpected packet", bPkt, 32'hxxxxxxxx);
            end else begin
                e = qB.pop_front();
                check("B packet", bPkt, e);
            end
        end
    end

    always @(negedge clk) begin : monC
        logic [31:0] e;
        if (!cRst && cReq && cGnt) begin
            if (qC.size() == 0) begin
                check("C unexpected packet", cPkt, 32'hxxxxxxxx);
            end else begin
                e = qC.pop_front();
                check("C packet", cPkt, e);
            end
        end
    end

    function automatic logic [7:0] lfsrStep(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    function automatic logic [5:0] randDest(input logic [7:0] s);
        return {1'b0, s[1:0], 1'b0, s[3:2]};
    endfunction

    initial begin : stim
        logic [7:0] m;
        logic [5:0] d;
        int         n;
        int         reqSeen;

        aRst = 1'b1; aEn = 1'b0; aFull = 1'b0;
        aAuto = 1'b1; manGnt = 1'b0;
        bRst = 1'b1; bEn = 1'b0;
        cRst = 1'b1; cEn = 1'b0;
        repeat (3) step();

        check("A reset req", {31'b0, aReq}, 32'd0);
        check("A reset pkt", aPkt, 32'd0);
        check("A reset cnt", {16'b0, aCnt}, 32'd0);
        check("A reset done", {31'b0, aDone}, 32'd0);

        qA.push_back(32'h001B_0000);
        qA.push_back(32'h001B_0040);
        qA.push_back(32'h001B_0080);
        aRst = 1'b0;
        aEn  = 1'b1;
        step();
        check("A first pkt", aPkt, 32'h001B_0000);
        for (int i = 0; i < 9; i++) begin
            check("A req pattern", {31'b0, aReq},
                  (i % 3 != 2) ? 32'd1 : 32'd0);
            if (i < 8) step();
        end
        check("A cnt after 3", {16'b0, aCnt}, 32'd3);

        aFull = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("A full blocks req", {31'b0, aReq}, 32'd0);
        end
        aFull = 1'b0;
        qA.push_back(32'h001B_00C0);
        step();
        check("A req after full", {31'b0, aReq}, 32'd1);
        check("A pkt after full", aPkt, 32'h001B_00C0);
        step();
        step();
        check("A req released", {31'b0, aReq}, 32'd0);

        aAuto  = 1'b0;
        manGnt = 1'b0;
        qA.push_back(32'h001B_0100);
        step();
        check("A hold req start", {31'b0, aReq}, 32'd1);
        for (int i = 0; i < 20; i++) begin
            aFull = i[0];
            aEn   = i[1];
            step();
            check("A hold req", {31'b0, aReq}, 32'd1);
            check("A hold pkt", aPkt, 32'h001B_0100);
        end
        manGnt = 1'b1;
        aEn    = 1'b0;
        aFull  = 1'b0;
        step();
        manGnt = 1'b0;
        check("A req after grant", {31'b0, aReq}, 32'd0);
        check("A cnt 5", {16'b0, aCnt}, 32'd5);

        aEn = 1'b1;
        step();
        check("A req before reset", {31'b0, aReq}, 32'd1);
        aRst   = 1'b1;
        manGnt = 1'b1;
        step();
        manGnt = 1'b0;
        check("A req at reset", {31'b0, aReq}, 32'd0);
        check("A cnt at reset", {16'b0, aCnt}, 32'd0);
        check("A pkt at reset", aPkt, 32'd0);
        aRst  = 1'b0;
        aAuto = 1'b1;
        qA.push_back(32'h001B_0000);
        step();
        check("A restart req", {31'b0, aReq}, 32'd1);
        check("A restart pkt", aPkt, 32'h001B_0000);
        n = 0;
        while (aCnt != 16'd1 && n < 20) begin
            step();
            n++;
        end
        aEn = 1'b0;
        check("A restart cnt", {16'b0, aCnt}, 32'd1);
        check("A queue drained", qA.size(), 32'd0);

        m = 8'hA5;
        for (int i = 0; i < 200; i++) begin
            d = randDest(m);
            while (d == 6'b0) begin
                m = lfsrStep(m);
                d = randDest(m);
            end
            qB.push_back({10'b0, d, 10'(i), 6'h2A});
            m = lfsrStep(m);
        end
        bRst = 1'b0;
        bEn  = 1'b1;
        n = 0;
        while (bCnt != 16'd200 && n < 5000) begin
            step();
            n++;
        end
        bEn = 1'b0;
        check("B cnt 200", {16'b0, bCnt}, 32'd200);
        check("B bad destinations", bBad, 32'd0);
        check("B queue drained", qB.size(), 32'd0);

        qC.push_back(32'h0011_0011);
        qC.push_back(32'h0011_0051);
        qC.push_back(32'h0011_0091);
        cRst = 1'b0;
        cEn  = 1'b1;
        n = 0;
        while (cCnt != 16'd2 && n < 100) begin
            step();
            n++;
        end
        check("C cnt 2", {16'b0, cCnt}, 32'd2);
        check("C done low at 2", {31'b0, cDone}, 32'd0);
        n = 0;
        while (cCnt != 16'd3 && n < 100) begin
            step();
            n++;
        end
        check("C cnt 3", {16'b0, cCnt}, 32'd3);
        check("C done at 3", {31'b0, cDone}, 32'd1);
        reqSeen = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (cReq) reqSeen++;
        end
        check("C no req after done", reqSeen, 32'd0);
        check("C cnt stays 3", {16'b0, cCnt}, 32'd3);
        check("C done stays", {31'b0, cDone}, 32'd1);
        check("C queue drained", qC.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nChecks, nFail);
        $finish;
    end

endmodule
